ir_sample_ctrl: RTL and testbench
=================================

// Module: ir_sample_ctrl
// PURPOSE
//  Sequences IR wall-sensor sampling for heading fusion: pulses IR emitters, runs left then right
//  A2D conversions, classifies each side open/closed with hysteresis, and forms the derivative term.
//  Registered outputs feed the IR heading-adjust math, once per sample period.
//  Sits between the A2D interface block and the heading-fusion datapath.
// PARAMETERS
//  PERIOD    20'd500000  clk cycles between sample starts (>= SETTLE+2*TMO+8)
//  SETTLE    10'd256     emitter-on cycles before first conversion
//  TMO       12'd2048    max cycles waiting on cnv_cmplt before abort
//  OPN_THRES 12'h200     open threshold; reading below = no wall
//  HYST      12'h040     hysteresis half-band around OPN_THRES
//  L_CHNL    3'd0        A2D channel, left sensor
//  R_CHNL    3'd4        A2D channel, right sensor
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active high
//  en         in   1   sampling enable; low = finish current sample, then idle
//  strt_cnv   out  1   one-cycle pulse starting an A2D conversion
//  chnl       out  3   A2D channel select, valid while strt_cnv high and until cnv_cmplt
//  cnv_cmplt  in   1   one-cycle pulse: res valid
//  res        in   12  A2D result, unsigned
//  IR_en      out  1   emitter enable
//  lft_IR     out  12  latched left reading
//  rght_IR    out  12  latched right reading
//  lft_opn    out  1   left side open
//  rght_opn   out  1   right side open
//  IR_Dtrm    out  9   signed derivative term
//  en_fusion  out  1   IR fusion allowed
//  smpl_vld   out  1   one-cycle pulse: all outputs updated this cycle
//  a2d_err    out  1   sticky: conversion timeout; cleared by rst or next good sample
// BEHAVIOUR
//  Reset: all outputs 0, lft_opn=rght_opn=1, state IDLE, period counter 0, prev_err 0.
//  Period counter free-runs while en; wraps at PERIOD-1, raises tick. Counter cleared while !en.
//  FSM: IDLE -tick-> SETTLE (IR_en=1, SETTLE cycles) -> CNV_L (strt_cnv, chnl=L_CHNL,
//   wait cnv_cmplt) -> CNV_R (same, R_CHNL) -> CALC (IR_en=0, update outputs, smpl_vld=1) -> IDLE.
//  strt_cnv: exactly one cycle on entry to CNV_L/CNV_R. cnv_cmplt outside CNV_* ignored.
//  cnv_cmplt in the same cycle as strt_cnv is ignored (A2D latency >= 1).
//  tick while not IDLE is dropped, not queued. en low mid-sample: sample completes normally.
//  Timeout: TMO cycles in CNV_* without cnv_cmplt -> IR_en=0, a2d_err=1, en_fusion=0,
//   readings/opn/Dtrm held, no smpl_vld, return to IDLE.
//  Open detect per side (CALC): opn sets if reading < OPN_THRES-HYST, clears if reading >
//   OPN_THRES+HYST, else holds. Compare unsigned 12-bit.
//  err = (lft_IR - rght_IR) in 13-bit signed, arithmetic >>1, kept 12-bit (new readings).
//  If both sides closed this and previous sample: IR_Dtrm = sat9(err - prev_err), computed 13-bit,
//   clamped to [-256,+255]; else IR_Dtrm = 0. prev_err <= err every CALC.
//  en_fusion <= ~(lft_opn & rght_opn) using new flags; a2d_err cleared on good CALC.
//  All outputs registered; update visible the cycle after CALC entry (one cycle with smpl_vld).
//  Async rst mid-sample: immediate return to reset values, IR_en drops without waiting.
// STRUCTURE
//  Package ir_pkg: typedef enum {IDLE,SETTLE,CNV_L,CNV_R,CALC} ir_state_t; D_MAX=9'sd255,
//   D_MIN=-9'sd256; channel constants shared with A2D interface.
//  Sub-module ir_opn_det (hysteresis comparator: clk, rst, ld, rd, opn), instantiated per side.
//  One shared wait counter for SETTLE and TMO; separate period counter.
// TESTING
//  Nominal: en=1, A2D model returns L=12'h600, R=12'h500 -> lft_IR=600, rght_IR=500, opn=0/0,
//   en_fusion=1, smpl_vld once per PERIOD, strt_cnv chnl 0 then 4, IR_en high SETTLE+conv cycles.
//  Derivative: consecutive samples err 0x080 then 0x0C0 -> IR_Dtrm=+64; jump 0x000->0x400
//   -> IR_Dtrm=+255 saturated; 0x400->0x000 -> -256.
//  Hysteresis: left 0x1D0 (holds closed), 0x1B0 -> lft_opn=1, 0x220 holds open, 0x250 -> 0;
//   IR_Dtrm=0 on the sample after an opening.
//  Both open: L=R=12'h100 -> en_fusion=0, IR_Dtrm=0.
//  Timeout: suppress cnv_cmplt on right -> after TMO cycles a2d_err=1, IR_en=0, no smpl_vld,
//   outputs held; next good sample clears a2d_err.
//  Reset mid CNV_L and en drop mid SETTLE: rst -> reset values next edge; en=0 -> sample
//   completes, then IDLE with no further strt_cnv.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and constants for IR wall-sensor sampling: FSM states, A2D
// channel assignments, open-detect thresholds and derivative saturation.
package ir_pkg;

  typedef enum logic [2:0] {IDLE, SETTLE, CNV_L, CNV_R, CALC} ir_state_t;

  typedef logic [11:0]       ir_rd_t;
  typedef logic [2:0]        ir_chnl_t;
  typedef logic signed [8:0] ir_dtrm_t;

  localparam logic [19:0] PERIOD_DFLT = 20'd500000;
  localparam logic [9:0]  SETTLE_DFLT = 10'd256;
  localparam logic [11:0] TMO_DFLT    = 12'd2048;

  localparam ir_rd_t OPN_THRES = 12'h200;
  localparam ir_rd_t HYST      = 12'h040;
  localparam ir_rd_t OPN_LO    = OPN_THRES - HYST;
  localparam ir_rd_t OPN_HI    = OPN_THRES + HYST;

  localparam ir_chnl_t L_CHNL = 3'd0;
  localparam ir_chnl_t R_CHNL = 3'd4;

  localparam ir_dtrm_t D_MAX = 9'sd255;
  localparam ir_dtrm_t D_MIN = 9'sh100;

  function automatic ir_dtrm_t sat9(input logic signed [12:0] v);
    if (v > 13'sd255) return D_MAX;
    if (v < -13'sd256) return D_MIN;
    return 9'(v);
  endfunction

endpackage

// File: rtl/ir_sample_ctrl_if.sv
// Signal bundle linking the IR sample controller to the A2D interface block
// and to the heading-fusion datapath.
interface ir_sample_ctrl_if;
  import ir_pkg::*;

  logic     en;
  logic     strt_cnv;
  ir_chnl_t chnl;
  logic     cnv_cmplt;
  ir_rd_t   res;
  logic     IR_en;
  ir_rd_t   lft_IR;
  ir_rd_t   rght_IR;
  logic     lft_opn;
  logic     rght_opn;
  ir_dtrm_t IR_Dtrm;
  logic     en_fusion;
  logic     smpl_vld;
  logic     a2d_err;

  modport master (
    input  en, cnv_cmplt, res,
    output strt_cnv, chnl, IR_en, lft_IR, rght_IR, lft_opn, rght_opn,
           IR_Dtrm, en_fusion, smpl_vld, a2d_err
  );

  modport slave (
    output en, cnv_cmplt, res,
    input  strt_cnv, chnl, IR_en, lft_IR, rght_IR, lft_opn, rght_opn,
           IR_Dtrm, en_fusion, smpl_vld, a2d_err
  );

endinterface

// File: rtl/ir_opn_det.sv
// Per-side open/closed classifier with a hysteresis band around OPN_THRES.
// Flag updates on ld; opn_nxt exposes the value it will take so CALC can use it.
module ir_opn_det
  import ir_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ld,
  input  ir_rd_t rd,
  output logic   opn,
  output logic   opn_nxt
);

  logic opn_q;

  always_comb begin
    opn_nxt = opn_q;
    if (rd < OPN_LO)      opn_nxt = 1'b1;
    else if (rd > OPN_HI) opn_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     opn_q <= 1'b1;
    else if (ld) opn_q <= opn_nxt;
  end

  assign opn = opn_q;

endmodule

// File: rtl/ir_sample_ctrl.sv
// IR wall-sensor sequencer: emitter settle, left then right A2D conversion, open
// detect and saturated derivative; all outputs registered, valid the cycle after CALC.
module ir_sample_ctrl
  import ir_pkg::*;
#(
  parameter logic [19:0] PERIOD     = PERIOD_DFLT,
  parameter logic [9:0]  SETTLE_CYC = SETTLE_DFLT,
  parameter logic [11:0] TMO        = TMO_DFLT
) (
  input logic              clk,
  input logic              rst,
  ir_sample_ctrl_if.master bus
);

  ir_state_t         state_q, state_d;
  logic [19:0]       period_q, period_d;
  logic [11:0]       wait_q, wait_d;
  logic              tick, cmplt, timeout, calc;
  logic              ir_en_q, ir_en_d, strt_q, strt_d;
  ir_chnl_t          chnl_q, chnl_d;
  ir_rd_t            l_raw_q, r_raw_q, lft_q, rght_q;
  ir_dtrm_t          dtrm_q;
  logic signed [11:0] prev_err_q, err;
  logic signed [12:0] diff, delta;
  logic              en_fus_q, vld_q, a2d_err_q;
  logic              lft_opn, rght_opn, lft_opn_nxt, rght_opn_nxt, both_closed;

  assign tick     = bus.en && (period_q == PERIOD - 20'd1);
  assign period_d = (!bus.en || tick) ? '0 : period_q + 20'd1;
  // A2D latency is at least one cycle, so a completion alongside strt_cnv is stale
  assign cmplt    = bus.cnv_cmplt && !strt_q;
  assign calc     = (state_q == CALC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      period_q <= period_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q + 12'd1;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (tick) state_d = SETTLE;
      end
      SETTLE: if (wait_q == {2'b00, SETTLE_CYC} - 12'd1) begin
        state_d = CNV_L;
        wait_d  = '0;
      end
      CNV_L: if (cmplt) begin
        state_d = CNV_R;
        wait_d  = '0;
      end else if (wait_q == TMO - 12'd1) begin
        state_d = IDLE;
        timeout = 1'b1;
      end
      CNV_R: if (cmplt) begin
        state_d = CALC;
      end else if (wait_q == TMO - 12'd1) begin
        state_d = IDLE;
        timeout = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ir_en_d = (state_d == SETTLE) || (state_d == CNV_L) || (state_d == CNV_R);
    strt_d  = ((state_d == CNV_L) && (state_q != CNV_L)) ||
              ((state_d == CNV_R) && (state_q != CNV_R));
    chnl_d  = chnl_q;
    if (state_d == CNV_L)      chnl_d = L_CHNL;
    else if (state_d == CNV_R) chnl_d = R_CHNL;
  end

  assign diff        = $signed({1'b0, l_raw_q}) - $signed({1'b0, r_raw_q});
  assign err         = 12'(diff >>> 1);
  assign delta       = {err[11], err} - {prev_err_q[11], prev_err_q};
  assign both_closed = !lft_opn_nxt && !rght_opn_nxt && !lft_opn && !rght_opn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_en_q    <= 1'b0;
      strt_q     <= 1'b0;
      chnl_q     <= '0;
      l_raw_q    <= '0;
      r_raw_q    <= '0;
      lft_q      <= '0;
      rght_q     <= '0;
      dtrm_q     <= '0;
      prev_err_q <= '0;
      en_fus_q   <= 1'b0;
      vld_q      <= 1'b0;
      a2d_err_q  <= 1'b0;
    end else begin
      ir_en_q <= ir_en_d;
      strt_q  <= strt_d;
      chnl_q  <= chnl_d;
      vld_q   <= calc;
      if (state_q == CNV_L && cmplt) l_raw_q <= bus.res;
      if (state_q == CNV_R && cmplt) r_raw_q <= bus.res;
      if (calc) begin
        lft_q      <= l_raw_q;
        rght_q     <= r_raw_q;
        dtrm_q     <= both_closed ? sat9(delta) : '0;
        prev_err_q <= err;
        en_fus_q   <= ~(lft_opn_nxt & rght_opn_nxt);
        a2d_err_q  <= 1'b0;
      end else if (timeout) begin
        en_fus_q  <= 1'b0;
        a2d_err_q <= 1'b1;
      end
    end
  end

  ir_opn_det u_lft_det (
    .clk(clk), .rst(rst), .ld(calc), .rd(l_raw_q), .opn(lft_opn), .opn_nxt(lft_opn_nxt)
  );

  ir_opn_det u_rght_det (
    .clk(clk), .rst(rst), .ld(calc), .rd(r_raw_q), .opn(rght_opn), .opn_nxt(rght_opn_nxt)
  );

  assign bus.strt_cnv  = strt_q;
  assign bus.chnl      = chnl_q;
  assign bus.IR_en     = ir_en_q;
  assign bus.lft_IR    = lft_q;
  assign bus.rght_IR   = rght_q;
  assign bus.lft_opn   = lft_opn;
  assign bus.rght_opn  = rght_opn;
  assign bus.IR_Dtrm   = dtrm_q;
  assign bus.en_fusion = en_fus_q;
  assign bus.smpl_vld  = vld_q;
  assign bus.a2d_err   = a2d_err_q;

endmodule

// File: tb/tb_ir_sample_ctrl.sv
// Bench for ir_sample_ctrl: randomized-latency A2D model plus a per-sample
// reference model of readings, hysteresis flags, derivative and error status.
module tb_ir_sample_ctrl;
  import ir_pkg::*;

  localparam int PER   = 120;
  localparam int STL   = 8;
  localparam int TMOC  = 32;
  localparam int TH_LO = 'h200 - 'h40;
  localparam int TH_HI = 'h200 + 'h40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ir_sample_ctrl_if bus();

  ir_sample_ctrl #(
    .PERIOD(20'(PER)), .SETTLE_CYC(10'(STL)), .TMO(12'(TMOC))
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] lval = '0, rval = '0;
  bit suppress_r = 1'b0;
  int lat_l = 0, lat_r = 0;

  // A2D model: responds to each strt_cnv after 1..6 cycles with the channel's value
  initial begin
    bit pend;
    int cnt, lat;
    logic [2:0] pch;
    pend = 1'b0; cnt = 0; pch = '0;
    bus.cnv_cmplt = 1'b0;
    bus.res = '0;
    forever begin
      @(negedge clk);
      bus.cnv_cmplt = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            bus.cnv_cmplt = 1'b1;
            bus.res = (pch == L_CHNL) ? lval : rval;
            pend = 1'b0;
          end
        end
        if (bus.strt_cnv && !(suppress_r && bus.chnl == R_CHNL)) begin
          lat = $urandom_range(1, 6);
          pend = 1'b1; cnt = lat; pch = bus.chnl;
          if (pch == L_CHNL) lat_l = lat; else lat_r = lat;
        end
      end
    end
  end

  int nvld = 0, nstrt = 0, strt_cyc = 0, ir_run = 0, last_run = 0;
  int chq[$];
  initial begin
    forever begin
      @(negedge clk);
      if (bus.smpl_vld) nvld++;
      if (bus.strt_cnv) begin
        nstrt++;
        strt_cyc = cyc;
        chq.push_back(int'(bus.chnl));
      end
      if (bus.IR_en) ir_run++;
      else if (ir_run > 0) begin
        last_run = ir_run;
        ir_run = 0;
      end
    end
  end

  bit m_lo, m_ro, m_fus, m_err;
  int m_prev, m_dt;
  logic [11:0] m_l, m_r;
  int vld_cyc = 0, tick_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lo = 1'b1; m_ro = 1'b1; m_prev = 0; m_dt = 0;
    m_l = '0; m_r = '0; m_fus = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_good(input logic [11:0] l, input logic [11:0] r);
    bit was_closed;
    int e, d;
    was_closed = !m_lo && !m_ro;
    if (l < TH_LO) m_lo = 1'b1; else if (l > TH_HI) m_lo = 1'b0;
    if (r < TH_LO) m_ro = 1'b1; else if (r > TH_HI) m_ro = 1'b0;
    e = (int'(l) - int'(r)) >>> 1;
    d = e - m_prev;
    if (d > 255) d = 255;
    if (d < -256) d = -256;
    m_dt = (was_closed && !m_lo && !m_ro) ? d : 0;
    m_prev = e; m_l = l; m_r = r;
    m_fus = !(m_lo && m_ro);
    m_err = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    logic [8:0] ed;
    ed = 9'(m_dt);
    chk({tag, ".lft_IR"}, 32'(bus.lft_IR), 32'(m_l));
    chk({tag, ".rght_IR"}, 32'(bus.rght_IR), 32'(m_r));
    chk({tag, ".lft_opn"}, 32'(bus.lft_opn), 32'(m_lo));
    chk({tag, ".rght_opn"}, 32'(bus.rght_opn), 32'(m_ro));
    chk({tag, ".IR_Dtrm"}, {23'b0, bus.IR_Dtrm}, {23'b0, ed});
    chk({tag, ".en_fusion"}, 32'(bus.en_fusion), 32'(m_fus));
    chk({tag, ".a2d_err"}, 32'(bus.a2d_err), 32'(m_err));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".strt_cnv"}, 32'(bus.strt_cnv), 32'd0);
    chk({tag, ".chnl"}, 32'(bus.chnl), 32'd0);
    chk({tag, ".IR_en"}, 32'(bus.IR_en), 32'd0);
    chk({tag, ".lft_IR"}, 32'(bus.lft_IR), 32'd0);
    chk({tag, ".rght_IR"}, 32'(bus.rght_IR), 32'd0);
    chk({tag, ".lft_opn"}, 32'(bus.lft_opn), 32'd1);
    chk({tag, ".rght_opn"}, 32'(bus.rght_opn), 32'd1);
    chk({tag, ".IR_Dtrm"}, {23'b0, bus.IR_Dtrm}, 32'd0);
    chk({tag, ".en_fusion"}, 32'(bus.en_fusion), 32'd0);
    chk({tag, ".smpl_vld"}, 32'(bus.smpl_vld), 32'd0);
    chk({tag, ".a2d_err"}, 32'(bus.a2d_err), 32'd0);
  endtask

  task automatic do_sample(input string tag, input logic [11:0] l, input logic [11:0] r);
    int n, chseq;
    bit seen;
    n = 0; seen = 1'b0;
    lval = l; rval = r;
    chq.delete();
    while (!seen && n < 3 * PER) begin
      step();
      n++;
      if (bus.smpl_vld) seen = 1'b1;
    end
    chk({tag, ".vld_seen"}, 32'(seen), 32'd1);
    vld_cyc = cyc;
    model_good(l, r);
    check_outs(tag);
    chseq = (chq.size() == 2) ? chq[0] * 16 + chq[1] : -1;
    chk({tag, ".chnl_seq"}, chseq, int'(L_CHNL) * 16 + int'(R_CHNL));
    chk({tag, ".ir_en_len"}, last_run, STL + lat_l + lat_r + 2);
    tick_cyc = vld_cyc - 2 - last_run;
    step();
    chk({tag, ".vld_pulse"}, 32'(bus.smpl_vld), 32'd0);
  endtask

  function automatic logic [11:0] rand_rd();
    if ($urandom_range(0, 1) == 1) return 12'($urandom_range(0, 4095));
    return 12'($urandom_range('h1A0, 'h260));
  endfunction

  initial begin
    int n, v0, t0;
    bit seen;
    bus.en = 1'b0;
    model_reset();
    repeat (3) step();
    check_reset("reset");
    rst = 1'b0;
    bus.en = 1'b1;

    do_sample("nom0", 12'h600, 12'h500);
    chk("nom0.lft_IR_const", 32'(bus.lft_IR), 32'h600);
    t0 = tick_cyc;
    do_sample("nom1", 12'h600, 12'h500);
    chk("nom1.period", tick_cyc - t0, PER);
    t0 = tick_cyc;
    do_sample("nom2", 12'h600, 12'h500);
    chk("nom2.period", tick_cyc - t0, PER);

    do_sample("der_p64", 12'h680, 12'h500);
    chk("der_p64.const", {23'b0, bus.IR_Dtrm}, 32'd64);
    do_sample("der_zero", 12'h500, 12'h500);
    do_sample("der_sat_hi", 12'hC00, 12'h400);
    chk("der_sat_hi.const", {23'b0, bus.IR_Dtrm}, 32'd255);
    do_sample("der_sat_lo", 12'h600, 12'h600);
    chk("der_sat_lo.const", {23'b0, bus.IR_Dtrm}, 32'h100);

    do_sample("hys_1d0", 12'h1D0, 12'h500);
    chk("hys_1d0.const", 32'(bus.lft_opn), 32'd0);
    do_sample("hys_1b0", 12'h1B0, 12'h500);
    chk("hys_1b0.const", 32'(bus.lft_opn), 32'd1);
    do_sample("hys_220", 12'h220, 12'h500);
    chk("hys_220.const", 32'(bus.lft_opn), 32'd1);
    do_sample("hys_250", 12'h250, 12'h500);
    chk("hys_250.const", 32'(bus.lft_opn), 32'd0);

    do_sample("both_open", 12'h100, 12'h100);
    chk("both_open.const", 32'(bus.en_fusion), 32'd0);

    for (int i = 0; i < 12; i++) do_sample($sformatf("rnd%0d", i), rand_rd(), rand_rd());

    suppress_r = 1'b1;
    lval = 12'h650; rval = 12'h450;
    v0 = nvld; n = 0; seen = 1'b0;
    while (!seen && n < 3 * PER) begin
      step();
      n++;
      if (bus.a2d_err) seen = 1'b1;
    end
    chk("tmo.err_seen", 32'(seen), 32'd1);
    chk("tmo.latency", cyc - strt_cyc, TMOC);
    chk("tmo.IR_en", 32'(bus.IR_en), 32'd0);
    chk("tmo.no_vld", nvld - v0, 0);
    m_err = 1'b1;
    m_fus = 1'b0;
    check_outs("tmo");
    suppress_r = 1'b0;
    do_sample("post_tmo", 12'h700, 12'h300);

    n = 0; seen = 1'b0;
    while (!seen && n < 3 * PER) begin
      step();
      n++;
      if (bus.strt_cnv && bus.chnl == L_CHNL) seen = 1'b1;
    end
    chk("rstmid.strt_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    check_reset("rstmid");
    step();
    rst = 1'b0;
    model_reset();
    do_sample("after_rst", 12'h300, 12'h280);

    n = 0; seen = 1'b0;
    while (!seen && n < 3 * PER) begin
      step();
      n++;
      if (bus.IR_en) seen = 1'b1;
    end
    chk("endrop.ir_en_seen", 32'(seen), 32'd1);
    step();
    bus.en = 1'b0;
    do_sample("endrop", 12'h5A0, 12'h520);
    v0 = nstrt; t0 = nvld;
    repeat (3 * PER) step();
    chk("endrop.no_strt", nstrt - v0, 0);
    chk("endrop.no_vld", nvld - t0, 0);
    chk("endrop.IR_en", 32'(bus.IR_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
